// File: rtl/game_view_pkg.sv
// Shared types and constants for the game view and its draw engine.
// Screen geometry, palette, sprite kinds and engine states.
package game_view_pkg;

  localparam logic [7:0] SCREEN_W   = 8'd160;
  localparam logic [6:0] SCREEN_H   = 7'd120;
  localparam logic [6:0] SKY_ROWS   = 7'd20;
  localparam logic [6:0] GOLD_SIZE  = 7'd8;
  localparam logic [6:0] STONE_SIZE = 7'd6;

  localparam logic [2:0] SKY_COL   = 3'b011;
  localparam logic [2:0] DIRT_COL  = 3'b100;
  localparam logic [2:0] GOLD_COL  = 3'b110;
  localparam logic [2:0] STONE_COL = 3'b111;

  typedef enum logic [1:0] {
    KIND_BG    = 2'd0,
    KIND_GOLD  = 2'd1,
    KIND_STONE = 2'd2
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAW_BG  = 2'd1,
    S_DRAW_OBJ = 2'd2,
    S_DONE     = 2'd3
  } draw_state_e;

  // Done bit position per kind: {stone, gold, background}
  function automatic logic [2:0] kind_onehot(kind_e k);
    logic [2:0] v;
    v = 3'b000;
    unique case (k)
      KIND_BG:    v = 3'b001;
      KIND_GOLD:  v = 3'b010;
      KIND_STONE: v = 3'b100;
      default:    v = 3'b000;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] sprite_size(kind_e k);
    return (k == KIND_GOLD) ? GOLD_SIZE : STONE_SIZE;
  endfunction

endpackage

// File: rtl/draw_raster_counter.sv
// Two-dimensional raster position counter.
// Walks cx across a row, then steps cy; wraps to origin after the last pixel.
module draw_raster_counter #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last_pixel
);

  logic last_col;

  assign last_col   = (cx == width - 1'b1);
  assign last_pixel = last_col && (cy == height - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (load) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (last_pixel) begin
        cx <= '0;
        cy <= '0;
      end else if (last_col) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_draw_engine.sv
// Draw engine: rasterises background or a sprite into VGA adapter writes
// and answers the view FSM with a level done held until acknowledged.
module game_draw_engine
  import game_view_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_draw_background,
  input  logic       enable_draw_gold,
  input  logic       enable_draw_stone,
  input  logic [7:0] obj_x,
  input  logic [6:0] obj_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       draw_background_done,
  output logic       draw_gold_done,
  output logic       draw_stone_done
);

  draw_state_e state, state_n;
  kind_e       kind, kind_n;

  logic [7:0] ox, ox_n;
  logic [6:0] oy, oy_n;
  logic [7:0] x_n;
  logic [6:0] y_n;
  logic [2:0] col_n;
  logic       plot_n;
  logic [2:0] done_q, done_n;

  logic       cnt_load, cnt_en, last_pixel;
  logic [7:0] cx, cnt_w;
  logic [6:0] cy, cnt_h;

  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] en_vec, sel;
  logic       in_view, edge_x, edge_y, corner;

  assign en_vec = {enable_draw_stone, enable_draw_gold,
                   enable_draw_background};
  assign sel    = kind_onehot(kind);

  assign cnt_w = (state == S_DRAW_BG) ? SCREEN_W
                                      : {1'b0, sprite_size(kind)};
  assign cnt_h = (state == S_DRAW_BG) ? SCREEN_H : sprite_size(kind);

  // One bit of headroom so positions past the right/bottom edge clip
  assign px = {1'b0, ox} + {1'b0, cx};
  assign py = {1'b0, oy} + {1'b0, cy};

  assign in_view = (px < {1'b0, SCREEN_W}) && (py < {1'b0, SCREEN_H});
  assign edge_x  = (cx == '0) || (cx == {1'b0, GOLD_SIZE - 7'd1});
  assign edge_y  = (cy == '0) || (cy == GOLD_SIZE - 7'd1);
  assign corner  = (kind == KIND_GOLD) && edge_x && edge_y;

  draw_raster_counter #(.XW(8), .YW(7)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .en         (cnt_en),
    .width      (cnt_w),
    .height     (cnt_h),
    .cx         (cx),
    .cy         (cy),
    .last_pixel (last_pixel)
  );

  always_comb begin
    state_n  = state;
    kind_n   = kind;
    ox_n     = ox;
    oy_n     = oy;
    x_n      = vga_x;
    y_n      = vga_y;
    col_n    = colour;
    plot_n   = 1'b0;
    done_n   = 3'b000;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|en_vec) begin
          cnt_load = 1'b1;
          ox_n     = obj_x;
          oy_n     = obj_y;
          if (enable_draw_background) begin
            kind_n  = KIND_BG;
            state_n = S_DRAW_BG;
          end else begin
            kind_n  = enable_draw_gold ? KIND_GOLD : KIND_STONE;
            state_n = S_DRAW_OBJ;
          end
        end
      end
      S_DRAW_BG: begin
        cnt_en = 1'b1;
        plot_n = 1'b1;
        x_n    = cx;
        y_n    = cy;
        col_n  = (cy < SKY_ROWS) ? SKY_COL : DIRT_COL;
        if (last_pixel) state_n = S_DONE;
      end
      S_DRAW_OBJ: begin
        cnt_en = 1'b1;
        x_n    = px[7:0];
        y_n    = py[6:0];
        col_n  = (kind == KIND_GOLD) ? GOLD_COL : STONE_COL;
        plot_n = in_view && !corner;
        if (last_pixel) state_n = S_DONE;
      end
      S_DONE: begin
        done_n = sel;
        // Ack only counts once the done is visible to the requester
        if (|(done_q & sel) && |(en_vec & sel)) begin
          done_n  = 3'b000;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      kind   <= KIND_BG;
      ox     <= '0;
      oy     <= '0;
      vga_x  <= '0;
      vga_y  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      done_q <= '0;
    end else begin
      state  <= state_n;
      kind   <= kind_n;
      ox     <= ox_n;
      oy     <= oy_n;
      vga_x  <= x_n;
      vga_y  <= y_n;
      colour <= col_n;
      plot   <= plot_n;
      done_q <= done_n;
    end
  end

  assign draw_background_done = done_q[0];
  assign draw_gold_done       = done_q[1];
  assign draw_stone_done      = done_q[2];

endmodule

// File: tb/tb_game_draw_engine.sv
// Directed bench for game_draw_engine with a per-cycle expected-pixel
// model built from screen geometry, sprite shapes and clipping rules.
module tb_game_draw_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_bg, en_gold, en_stone;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       done_bg, done_gold, done_stone;

  game_draw_engine dut (
    .clk                    (clk),
    .reset                  (reset),
    .enable_draw_background (en_bg),
    .enable_draw_gold       (en_gold),
    .enable_draw_stone      (en_stone),
    .obj_x                  (obj_x),
    .obj_y                  (obj_y),
    .vga_x                  (vga_x),
    .vga_y                  (vga_y),
    .colour                 (colour),
    .plot                   (plot),
    .draw_background_done   (done_bg),
    .draw_gold_done         (done_gold),
    .draw_stone_done        (done_stone)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [2:0] d;
  } rec_t;

  rec_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         plots  = 0;
  bit         seen [0:255][0:127];
  logic [2:0] col_0_19, col_0_20;
  int         n;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected output per cycle: two quiet cycles, the raster, then done
  task automatic push_draw(input int kind, input int ox, input int oy);
    rec_t r;
    int   w, h, x, y;
    bit   vis;
    r = '{p: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, d: 3'd0};
    q.push_back(r);
    q.push_back(r);
    w = (kind == 0) ? 160 : (kind == 1) ? 8 : 6;
    h = (kind == 0) ? 120 : w;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        x   = (kind == 0) ? cx : ox + cx;
        y   = (kind == 0) ? cy : oy + cy;
        vis = (x < 160) && (y < 120);
        if (kind == 1 && (cx == 0 || cx == 7) && (cy == 0 || cy == 7))
          vis = 1'b0;
        r.p = vis;
        r.x = x[7:0];
        r.y = y[6:0];
        if (kind == 0) r.c = (y < 20) ? 3'b011 : 3'b100;
        else r.c = (kind == 1) ? 3'b110 : 3'b111;
        r.d = 3'd0;
        q.push_back(r);
      end
    end
    r = '{p: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, d: 3'(1 << kind)};
    q.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    plots = 0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 128; j++)
        seen[i][j] = 1'b0;
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("plot", {31'd0, plot}, {31'd0, r.p});
      chk("done", {29'd0, done_stone, done_gold, done_bg}, {29'd0, r.d});
      if (r.p) begin
        chk("vga_x", {24'd0, vga_x}, {24'd0, r.x});
        chk("vga_y", {25'd0, vga_y}, {25'd0, r.y});
        chk("colour", {29'd0, colour}, {29'd0, r.c});
      end
    end else begin
      chk("idle_plot", {31'd0, plot}, 32'd0);
    end
    if (plot === 1'b1) begin
      plots++;
      seen[vga_x][vga_y] = 1'b1;
      if (vga_x == 8'd0 && vga_y == 7'd19) col_0_19 = colour;
      if (vga_x == 8'd0 && vga_y == 7'd20) col_0_20 = colour;
    end
  end

  initial begin
    reset    = 1'b1;
    en_bg    = 1'b0;
    en_gold  = 1'b0;
    en_stone = 1'b0;
    obj_x    = 8'd0;
    obj_y    = 7'd0;
    col_0_19 = 3'd0;
    col_0_20 = 3'd0;
    clear_seen();
    repeat (3) tick();
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_done", {29'd0, done_stone, done_gold, done_bg}, 32'd0);
    chk("rst_pos", {17'd0, vga_x, vga_y}, 32'd0);
    chk("rst_colour", {29'd0, colour}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a background draw
    en_bg = 1'b1;
    push_draw(0, 0, 0);
    repeat (500) tick();
    reset = 1'b1;
    q.delete();
    en_bg = 1'b0;
    #1;
    chk("midrst_plot", {31'd0, plot}, 32'd0);
    chk("midrst_done", {29'd0, done_stone, done_gold, done_bg}, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("postrst_done", {29'd0, done_stone, done_gold, done_bg}, 32'd0);
    end

    // Full background with enable held high
    clear_seen();
    en_bg = 1'b1;
    push_draw(0, 0, 0);
    tick();
    n = 0;
    while (n < 30000) begin
      tick();
      n++;
      if (done_bg) break;
    end
    chk("bg_latency", n, 32'd19201);
    chk("bg_plots", plots, 32'd19200);
    chk("bg_sky_0_19", {29'd0, col_0_19}, 32'd3);
    chk("bg_dirt_0_20", {29'd0, col_0_20}, 32'd4);
    chk("bg_last_px", {31'd0, seen[159][119]}, 32'd1);
    tick();
    chk("bg_done_fall", {31'd0, done_bg}, 32'd0);
    en_bg = 1'b0;
    repeat (3) tick();

    // Gold with toggling enable; obj moves after start and must be ignored
    clear_seen();
    obj_x   = 8'd10;
    obj_y   = 7'd50;
    en_gold = 1'b1;
    push_draw(1, 10, 50);
    tick();
    obj_x = 8'd99;
    obj_y = 7'd3;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (done_gold) break;
      en_gold = ~en_gold;
    end
    en_gold = 1'b0;
    chk("gold_latency", n, 32'd65);
    chk("gold_plots", plots, 32'd60);
    chk("gold_c_10_50", {31'd0, seen[10][50]}, 32'd0);
    chk("gold_c_17_50", {31'd0, seen[17][50]}, 32'd0);
    chk("gold_c_10_57", {31'd0, seen[10][57]}, 32'd0);
    chk("gold_c_17_57", {31'd0, seen[17][57]}, 32'd0);
    chk("gold_px_11_50", {31'd0, seen[11][50]}, 32'd1);
    chk("gold_px_17_56", {31'd0, seen[17][56]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gold_done_hold", {31'd0, done_gold}, 32'd1);
    end
    en_gold = 1'b1;
    tick();
    en_gold = 1'b0;
    chk("gold_done_ack", {31'd0, done_gold}, 32'd0);
    repeat (3) tick();

    // Stone clipped at the bottom-right corner
    clear_seen();
    obj_x    = 8'd157;
    obj_y    = 7'd118;
    en_stone = 1'b1;
    push_draw(2, 157, 118);
    tick();
    en_stone = 1'b0;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (done_stone) break;
    end
    chk("stone_latency", n, 32'd37);
    chk("stone_plots", plots, 32'd6);
    chk("stone_px_157_118", {31'd0, seen[157][118]}, 32'd1);
    chk("stone_px_159_119", {31'd0, seen[159][119]}, 32'd1);
    en_stone = 1'b1;
    tick();
    en_stone = 1'b0;
    chk("stone_done_ack", {31'd0, done_stone}, 32'd0);
    repeat (3) tick();

    // Gold and stone together: gold wins, stone cannot ack gold
    clear_seen();
    obj_x    = 8'd30;
    obj_y    = 7'd60;
    en_gold  = 1'b1;
    en_stone = 1'b1;
    push_draw(1, 30, 60);
    tick();
    en_gold = 1'b0;
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (done_gold) break;
    end
    chk("prio_latency", n, 32'd65);
    chk("prio_plots", plots, 32'd60);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("prio_gold_hold", {31'd0, done_gold}, 32'd1);
      chk("prio_stone_done", {31'd0, done_stone}, 32'd0);
    end
    en_gold = 1'b1;
    tick();
    en_gold  = 1'b0;
    en_stone = 1'b0;
    chk("prio_gold_ack", {31'd0, done_gold}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("prio_quiet", {29'd0, done_stone, done_gold, done_bg}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
